// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage feeding the ALU: 2R/1W register file with writeback bypass and one output register.
// Optional OPF_ILLEGAL_OP_EN drops opcodes 011/100/101 on accept and raises a sticky illegal_op flag.
module alu_operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [2:0]        in_aluop,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [2:0]        out_aluop,
  output logic [ADDR_W-1:0] out_rd,
  output logic              illegal_op
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];

  logic              r_vld_p1;
  logic [DATA_W-1:0] r_a_p1;
  logic [DATA_W-1:0] r_b_p1;
  logic [2:0]        r_op_p1;
  logic [ADDR_W-1:0] r_rd_p1;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_drop;
  logic              w_load;
  logic              w_wr;
  logic [DATA_W-1:0] w_a_p0;
  logic [DATA_W-1:0] w_b_p0;

`ifdef OPF_ILLEGAL_OP_EN
  function automatic logic is_illegal(input logic [2:0] op);
    return (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
  endfunction
`endif

  // Stage p0: register read with same-cycle writeback bypass
  assign w_wr = wb_en && (wb_addr != '0);

  always_comb begin
    w_a_p0 = r_regs[in_rs1];
    w_b_p0 = r_regs[in_rs2];
    if (in_rs1 == '0)
      w_a_p0 = '0;
    else if (w_wr && (wb_addr == in_rs1))
      w_a_p0 = wb_data;
    if (in_rs2 == '0)
      w_b_p0 = '0;
    else if (w_wr && (wb_addr == in_rs2))
      w_b_p0 = wb_data;
  end

  assign w_in_ready = ~r_vld_p1 | out_ready;
  assign w_accept   = in_valid & w_in_ready;

`ifdef OPF_ILLEGAL_OP_EN
  assign w_drop = is_illegal(in_aluop);
`else
  assign w_drop = 1'b0;
`endif

  assign w_load = w_accept & ~w_drop;

  // Stage p1: output register holds the snapshot until the ALU consumes it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= '0;
      r_vld_p1 <= 1'b0;
      r_a_p1   <= '0;
      r_b_p1   <= '0;
      r_op_p1  <= '0;
      r_rd_p1  <= '0;
    end else begin
      if (w_wr)
        r_regs[wb_addr] <= wb_data;
      if (w_load) begin
        r_vld_p1 <= 1'b1;
        r_a_p1   <= w_a_p0;
        r_b_p1   <= w_b_p0;
        r_op_p1  <= in_aluop;
        r_rd_p1  <= in_rd;
      end else if (out_ready) begin
        r_vld_p1 <= 1'b0;
      end
    end
  end

`ifdef OPF_ILLEGAL_OP_EN
  logic r_illegal;

  always_ff @(posedge clk) begin
    if (rst)
      r_illegal <= 1'b0;
    else if (w_accept && w_drop)
      r_illegal <= 1'b1;
  end

  assign illegal_op = r_illegal;
`else
  assign illegal_op = 1'b0;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_vld_p1;
  assign out_a     = r_a_p1;
  assign out_b     = r_b_p1;
  assign out_aluop = r_op_p1;
  assign out_rd    = r_rd_p1;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Randomized bench for alu_operand_fetch against a behavioural register-file/output-slot model.
module tb_alu_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [2:0]  in_aluop;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b;
  logic [2:0]  out_aluop;
  logic [4:0]  out_rd;
  logic        illegal_op;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic [4:0]  m_rd;
  logic        m_ill;

  alu_operand_fetch #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_aluop(in_aluop),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_aluop(out_aluop), .out_rd(out_rd),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic dropped(input logic [2:0] op);
`ifdef OPF_ILLEGAL_OP_EN
    return op inside {3'b011, 3'b100, 3'b101};
`else
    return (op != op);
`endif
  endfunction

  function automatic logic [31:0] rd_reg(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && wb_addr == idx) return wb_data;
    return m_regs[idx];
  endfunction

  task automatic model_edge();
    logic acc;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_valid = 1'b0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_ill = 1'b0;
      return;
    end
    acc = in_valid && (!m_valid || out_ready);
    if (acc && !dropped(in_aluop)) begin
      m_a = rd_reg(in_rs1); m_b = rd_reg(in_rs2);
      m_op = in_aluop; m_rd = in_rd; m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (acc && dropped(in_aluop)) m_ill = 1'b1;
    if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
  endtask

  // One clock: check the combinational ready, advance the model, compare the registered outputs.
  task automatic step();
    @(negedge clk);
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
    model_edge();
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("out_a", out_a, m_a);
    chk("out_b", out_b, m_b);
    chk("out_aluop", {29'd0, out_aluop}, {29'd0, m_op});
    chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
    chk("illegal_op", {31'd0, illegal_op}, {31'd0, m_ill});
  endtask

  task automatic idle();
    rst = 1'b0; in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_aluop = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [2:0] op);
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_aluop = op;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = 32'hDEAD_BEEF;
    m_valid = 1'bx; m_a = 'x; m_b = 'x; m_op = 'x; m_rd = 'x; m_ill = 1'bx;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_op}, 32'd0);

    // Write r3, then read it back with rs2=r0
    idle(); wb(5'd3, 32'h0000_00AA); step();
    idle(); issue(5'd3, 5'd0, 5'd9, 3'b010); step();
    chk("wr_rd_a", out_a, 32'h0000_00AA);
    chk("wr_rd_b", out_b, 32'd0);
    chk("wr_rd_op", {29'd0, out_aluop}, 32'd2);

    // Writes to r0 are ignored
    idle(); wb(5'd0, 32'hFFFF_FFFF); step();
    idle(); issue(5'd0, 5'd3, 5'd1, 3'b001); step();
    chk("r0_a", out_a, 32'd0);

    // Same-cycle bypass on both operands
    idle(); wb(5'd7, 32'h1234_5678); issue(5'd7, 5'd7, 5'd2, 3'b110); step();
    chk("byp_a", out_a, 32'h1234_5678);
    chk("byp_b", out_b, 32'h1234_5678);

    // Backpressure: held op frozen; a wb to its source does not alter it
    idle(); out_ready = 1'b0; issue(5'd3, 5'd3, 5'd4, 3'b111); wb(5'd7, 32'h0BAD_0BAD);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_a", out_a, 32'h1234_5678);
    end
    idle(); out_ready = 1'b1; issue(5'd3, 5'd7, 5'd4, 3'b111); wb(5'd5, 32'h0000_0055); step();
    chk("bp_resume_a", out_a, 32'h0000_00AA);
    chk("bp_resume_b", out_b, 32'h0BAD_0BAD);
    chk("bp_resume_v", {31'd0, out_valid}, 32'd1);

    // Reset while holding an op; wb in the reset cycle is ignored
    idle(); out_ready = 1'b0; rst = 1'b1; wb(5'd5, 32'h0000_0099); step();
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_a", out_a, 32'd0);
    idle(); issue(5'd5, 5'd7, 5'd3, 3'b000); step();
    chk("midrst_r5", out_a, 32'd0);
    chk("midrst_r7", out_b, 32'd0);

    // Opcode 100 then a legal 001
    idle(); step();
    idle(); wb(5'd2, 32'h0000_0F0F); step();
    idle(); issue(5'd2, 5'd0, 5'd6, 3'b100); step();
`ifdef OPF_ILLEGAL_OP_EN
    chk("ill_valid", {31'd0, out_valid}, 32'd0);
    chk("ill_flag", {31'd0, illegal_op}, 32'd1);
`else
    chk("ill_valid", {31'd0, out_valid}, 32'd1);
    chk("ill_op_fwd", {29'd0, out_aluop}, 32'd4);
    chk("ill_flag", {31'd0, illegal_op}, 32'd0);
`endif
    idle(); issue(5'd2, 5'd2, 5'd6, 3'b001); step();
    chk("leg_valid", {31'd0, out_valid}, 32'd1);
    chk("leg_a", out_a, 32'h0000_0F0F);
`ifdef OPF_ILLEGAL_OP_EN
    chk("leg_flag", {31'd0, illegal_op}, 32'd1);
`endif

    // Randomized traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_rs1    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      in_rs2    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      in_rd     = 5'($urandom);
      in_aluop  = 3'($urandom);
      wb_en     = ($urandom_range(0, 1) != 0);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
